// File: rtl/irq_priority_encoder.sv
// 68k interrupt front end: synchronises IRQ sources, priority-encodes them onto IPLn, runs IACK.
// Optional build macro IRQ_EDGE_LATCH_EN turns IRQ2n/IRQ3n into edge-latched pending requests.
//
// state     | meaning
// IDLE      | no acknowledge in progress
// ACK_DUART | IACK claimed by the DUART, DUAIACKn low
// ACK_AUTO  | IACK for a non-vectored source, AVECn low
// ACK_SPUR  | IACK with nothing at the acknowledged level, IACK_BERRn low
module irq_priority_encoder #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 2,
  parameter int DUART_LEVEL   = 4
) (
  input  logic       CLK,
  input  logic       HWRST,
  input  logic       IRQ2n,
  input  logic       IRQ3n,
  input  logic       IRQ5n,
  input  logic       IRQ6n,
  input  logic       DUAIRQn,
  input  logic       ASn,
  input  logic [2:0] FC,
  input  logic [6:0] A_IACK,
  output logic [2:0] IPLn,
  output logic       DUAIACKn,
  output logic       AVECn,
  output logic       IACK_BERRn
);

  localparam logic [2:0] DUART_LVL   = 3'(DUART_LEVEL);
  localparam logic [2:0] STABLE_LOAD = 3'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ACK_DUART, ACK_AUTO, ACK_SPUR} state_t;

  state_t     state_q, state_d;
  logic [5:0] raw_in;
  logic [5:0] sync_q [SYNC_STAGES];
  logic [5:0] synced;
  logic       src2, src3, src5, src6, src_duart, as_low;
  logic [2:0] level, cand_q, stab_cnt, ipl_q, ack_lvl;
  logic       iack, duart_hit, other_hit, enter_auto;

  // bit order: {ASn, DUAIRQn, IRQ6n, IRQ5n, IRQ3n, IRQ2n}; all inactive-high
  assign raw_in = {ASn, DUAIRQn, IRQ6n, IRQ5n, IRQ3n, IRQ2n};

  always_ff @(posedge CLK) begin
    if (HWRST) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '1;
    end else begin
      sync_q[0] <= raw_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign synced    = sync_q[SYNC_STAGES-1];
  assign src5      = ~synced[2];
  assign src6      = ~synced[3];
  assign src_duart = ~synced[4];
  assign as_low    = ~synced[5];

`ifdef IRQ_EDGE_LATCH_EN
  logic pend2_q, pend3_q, set2, set3, clr2, clr3;

  // falling edge seen one stage early so pending flags have the same latency as level inputs
  assign set2 = synced[0] & ~sync_q[SYNC_STAGES-2][0];
  assign set3 = synced[1] & ~sync_q[SYNC_STAGES-2][1];
  assign clr2 = enter_auto && (ack_lvl == 3'd2);
  assign clr3 = enter_auto && (ack_lvl == 3'd3);

  always_ff @(posedge CLK) begin
    if (HWRST) begin
      pend2_q <= 1'b0;
      pend3_q <= 1'b0;
    end else begin
      if (set2)      pend2_q <= 1'b1;
      else if (clr2) pend2_q <= 1'b0;
      if (set3)      pend3_q <= 1'b1;
      else if (clr3) pend3_q <= 1'b0;
    end
  end

  assign src2 = pend2_q;
  assign src3 = pend3_q;
`else
  assign src2 = ~synced[0];
  assign src3 = ~synced[1];
`endif

  always_comb begin
    level = 3'd0;
    if (src2 && (level < 3'd2))           level = 3'd2;
    if (src3 && (level < 3'd3))           level = 3'd3;
    if (src_duart && (level < DUART_LVL)) level = DUART_LVL;
    if (src5 && (level < 3'd5))           level = 3'd5;
    if (src6 && (level < 3'd6))           level = 3'd6;
  end

  // stability filter: down-counter reloaded on every candidate change
  always_ff @(posedge CLK) begin
    if (HWRST) begin
      cand_q   <= 3'd0;
      stab_cnt <= 3'd0;
      ipl_q    <= 3'b111;
    end else if (level != cand_q) begin
      cand_q   <= level;
      stab_cnt <= STABLE_LOAD;
      if (STABLE_LOAD == 3'd0) ipl_q <= ~level;
    end else begin
      if (stab_cnt != 3'd0) stab_cnt <= stab_cnt - 3'd1;
      if (stab_cnt <= 3'd1) ipl_q <= ~level;
    end
  end

  assign IPLn = ipl_q;

  assign ack_lvl   = A_IACK[2:0];
  assign iack      = as_low && (FC == 3'b111) && (A_IACK[6:3] == 4'hF);
  assign duart_hit = src_duart && (ack_lvl == DUART_LVL);
  assign other_hit = (src6 && (ack_lvl == 3'd6)) || (src5 && (ack_lvl == 3'd5)) ||
                     (src3 && (ack_lvl == 3'd3)) || (src2 && (ack_lvl == 3'd2));

  always_ff @(posedge CLK) begin
    if (HWRST) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (iack) begin
          if (duart_hit)      state_d = ACK_DUART;
          else if (other_hit) state_d = ACK_AUTO;
          else                state_d = ACK_SPUR;
        end
      end
      default: if (!as_low) state_d = IDLE;
    endcase
  end

  assign enter_auto = (state_q == IDLE) && (state_d == ACK_AUTO);

  // strobes drop out on the same edge synced ASn goes high, one edge before the FSM returns
  always_comb begin
    DUAIACKn   = 1'b1;
    AVECn      = 1'b1;
    IACK_BERRn = 1'b1;
    if (as_low) begin
      case (state_q)
        ACK_DUART: DUAIACKn   = 1'b0;
        ACK_AUTO:  AVECn      = 1'b0;
        ACK_SPUR:  IACK_BERRn = 1'b0;
        default:   ;
      endcase
    end
  end

endmodule

// File: tb/tb_irq_priority_encoder.sv
// Directed bench for irq_priority_encoder at default parameters.
// Follows IRQ_EDGE_LATCH_EN the same way the design does.
module tb_irq_priority_encoder;

  logic       CLK = 1'b0;
  logic       HWRST;
  logic       IRQ2n, IRQ3n, IRQ5n, IRQ6n, DUAIRQn, ASn;
  logic [2:0] FC;
  logic [6:0] A_IACK;
  logic [2:0] IPLn;
  logic       DUAIACKn, AVECn, IACK_BERRn;

  int n_cmp = 0;
  int n_err = 0;

  irq_priority_encoder dut (
    .CLK(CLK), .HWRST(HWRST), .IRQ2n(IRQ2n), .IRQ3n(IRQ3n), .IRQ5n(IRQ5n), .IRQ6n(IRQ6n),
    .DUAIRQn(DUAIRQn), .ASn(ASn), .FC(FC), .A_IACK(A_IACK), .IPLn(IPLn),
    .DUAIACKn(DUAIACKn), .AVECn(AVECn), .IACK_BERRn(IACK_BERRn)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  function automatic logic [2:0] strb();
    return {DUAIACKn, AVECn, IACK_BERRn};
  endfunction

  initial begin
    HWRST = 1'b1; IRQ2n = 1'b1; IRQ3n = 1'b1; IRQ5n = 1'b1; IRQ6n = 1'b0;
    DUAIRQn = 1'b1; ASn = 1'b1; FC = 3'd0; A_IACK = 7'd0;

    // reset with IRQ6 held, then exact release latency
    tick(3);
    chk("rst_ipl", IPLn, 3'b111);
    chk("rst_strb", strb(), 3'b111);
    HWRST = 1'b0;
    tick(3);
    chk("rst_lat3", IPLn, 3'b111);
    tick(1);
    chk("rst_lat4", IPLn, 3'b001);
    IRQ6n = 1'b1;
    tick(6);
    chk("irq6_rel", IPLn, 3'b111);

    // priority between IRQ5 and IRQ3
    IRQ3n = 1'b0; IRQ5n = 1'b0;
    tick(4);
    chk("prio_5", IPLn, 3'b010);
    IRQ5n = 1'b1;
    tick(3);
    chk("prio_hold", IPLn, 3'b010);
    tick(1);
    chk("prio_3", IPLn, 3'b100);
    IRQ3n = 1'b1;
    tick(6);
    chk("prio_none", IPLn, 3'b111);

    // one-clock glitch must be filtered
    IRQ6n = 1'b0;
    tick(1);
    IRQ6n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("glitch", IPLn, 3'b111);
      tick(1);
    end

    // DUART vectored acknowledge
    DUAIRQn = 1'b0;
    tick(6);
    chk("duart_ipl", IPLn, 3'b011);
    ASn = 1'b0; FC = 3'b111; A_IACK = 7'b1111_100;
    tick(2);
    chk("duart_e2", strb(), 3'b111);
    tick(1);
    chk("duart_e3", strb(), 3'b011);
    ASn = 1'b1;
    tick(1);
    chk("duart_rel1", strb(), 3'b011);
    tick(1);
    chk("duart_rel2", strb(), 3'b111);
    DUAIRQn = 1'b1;
    tick(6);

    // autovector at level 5
    IRQ5n = 1'b0;
    tick(4);
    ASn = 1'b0; FC = 3'b111; A_IACK = 7'b1111_101;
    tick(3);
    chk("auto5", strb(), 3'b101);
    chk("auto5_ipl", IPLn, 3'b010);
    ASn = 1'b1;
    tick(3);
    chk("auto5_rel", strb(), 3'b111);

    // non-IACK bus cycle leaves every strobe high
    ASn = 1'b0; FC = 3'b110;
    tick(5);
    chk("non_iack", strb(), 3'b111);
    ASn = 1'b1;
    IRQ5n = 1'b1;
    tick(6);

    // spurious acknowledge, then reset mid-ack
    ASn = 1'b0; FC = 3'b111; A_IACK = 7'b1111_010;
    tick(3);
    chk("spur2", strb(), 3'b110);
    HWRST = 1'b1;
    tick(1);
    chk("spur_rst", strb(), 3'b111);
    HWRST = 1'b0; ASn = 1'b1;
    tick(4);
    chk("post_rst", strb(), 3'b111);

    // single-clock IRQ2 pulse
    IRQ2n = 1'b0;
    tick(1);
    IRQ2n = 1'b1;
    tick(6);
`ifdef IRQ_EDGE_LATCH_EN
    chk("latch_ipl", IPLn, 3'b101);
    ASn = 1'b0; FC = 3'b111; A_IACK = 7'b1111_010;
    tick(3);
    chk("latch_ack", strb(), 3'b101);
    ASn = 1'b1;
    tick(6);
    chk("latch_clr", IPLn, 3'b111);
`else
    chk("nolatch_ipl", IPLn, 3'b111);
    ASn = 1'b0; FC = 3'b111; A_IACK = 7'b1111_010;
    tick(3);
    chk("nolatch_ack", strb(), 3'b110);
    ASn = 1'b1;
    tick(6);
    chk("nolatch_end", IPLn, 3'b111);
`endif
    chk("final_strb", strb(), 3'b111);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
